alu_share_arbiter: RTL and testbench

- Shares the single 32-bit combinational ALU (5-bit ALUControl, A, B in; ALUResult, Zero out) between two requesters, e.g. the execute stage and a multi-cycle address/loop unit.
- Accepts one operation at a time with valid/ready handshakes and arbitrates round-robin.
- Drives the ALU from registered operands, holds multiply operands for extra cycles, and returns the registered result to the owning requester.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/alu_share_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl opcodes and the states of the ALU-sharing FSM.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_MUL  = 5'b00011;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_AND  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00111;
    localparam logic [4:0] ALU_XOR  = 5'b01000;
    localparam logic [4:0] ALU_BGEZ = 5'b01011;
    localparam logic [4:0] ALU_BEQ  = 5'b01100;
    localparam logic [4:0] ALU_NOR  = 5'b01101;
    localparam logic [4:0] ALU_SLT  = 5'b01110;
    localparam logic [4:0] ALU_BNE  = 5'b01111;
    localparam logic [4:0] ALU_BGTZ = 5'b10000;
    localparam logic [4:0] ALU_BLEZ = 5'b10001;
    localparam logic [4:0] ALU_BLTZ = 5'b10010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        MULWAIT = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer moves away from the finishing owner
// when done pulses, so the last winner has lowest priority on the next tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_id,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= ~done_id;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two valid/ready requesters, holding
// operands for multi-cycle multiplies and returning a registered result to the owner.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter logic [4:0]  MUL_OP  = ALU_MUL
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [1:0]  ReqValid,
    output logic [1:0]  ReqReady,
    input  logic [4:0]  ReqOp0,
    input  logic [4:0]  ReqOp1,
    input  logic [31:0] ReqA0,
    input  logic [31:0] ReqA1,
    input  logic [31:0] ReqB0,
    input  logic [31:0] ReqB1,
    output logic [1:0]  RespValid,
    input  logic [1:0]  RespReady,
    output logic [31:0] RespResult,
    output logic        RespZero,
    output logic [4:0]  ALUControl,
    output logic [31:0] ALUA,
    output logic [31:0] ALUB,
    input  logic [31:0] ALUResult,
    input  logic        ALUZero
);

    localparam logic [3:0] MUL_LOAD = (MUL_LAT == 0) ? 4'd0 : 4'(MUL_LAT - 1);

    arb_state_t  state, state_next;
    logic [4:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        owner_q;
    logic [3:0]  cnt_q;
    logic [1:0]  arb_req, grant;
    logic        accept, sample, short_op, resp_done, alu_drive;

    // Requests only compete while idle, so the grant is zero during a transaction.
    assign arb_req   = (state == IDLE) ? ReqValid : 2'b00;
    assign accept    = |grant;
    assign short_op  = (op_q != MUL_OP) || (MUL_LAT == 0);
    assign resp_done = (state == RESP) && RespReady[owner_q];
    assign alu_drive = (state == ISSUE) || (state == MULWAIT);

    rr_arbiter2 u_rr (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .req     (arb_req),
        .done    (resp_done),
        .done_id (owner_q),
        .grant   (grant)
    );

    assign ReqReady   = grant & {2{Reset_n}};
    assign RespValid  = (state == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign ALUControl = alu_drive ? op_q : 5'd0;
    assign ALUA       = alu_drive ? a_q  : 32'd0;
    assign ALUB       = alu_drive ? b_q  : 32'd0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (short_op) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = MULWAIT;
                end
            end
            MULWAIT: begin
                if (cnt_q == 4'd0) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at acceptance, multiply hold counter and result sampling.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_q       <= 5'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            owner_q    <= 1'b0;
            cnt_q      <= 4'd0;
            RespResult <= 32'd0;
            RespZero   <= 1'b0;
        end else begin
            if ((state == IDLE) && accept) begin
                owner_q <= grant[1];
                op_q    <= grant[1] ? ReqOp1 : ReqOp0;
                a_q     <= grant[1] ? ReqA1  : ReqA0;
                b_q     <= grant[1] ? ReqB1  : ReqB0;
            end
            if (state == ISSUE) begin
                cnt_q <= MUL_LOAD;
            end else if ((state == MULWAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (sample) begin
                RespResult <= ALUResult;
                RespZero   <= ALUZero;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: a transaction-level model of the shared ALU arbiter plus a
// behavioural ALU, with directed scenarios followed by randomized two-requester traffic.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int MUL_LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic [1:0]  ReqValid = 2'b00, ReqReady, RespValid, RespReady = 2'b00;
    logic [4:0]  ReqOp0 = '0, ReqOp1 = '0, ALUControl;
    logic [31:0] ReqA0 = '0, ReqA1 = '0, ReqB0 = '0, ReqB1 = '0;
    logic [31:0] RespResult, ALUA, ALUB, ALUResult;
    logic        RespZero, ALUZero;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    alu_share_arbiter #(.MUL_LAT(MUL_LAT), .MUL_OP(ALU_MUL)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp0(ReqOp0), .ReqOp1(ReqOp1),
        .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
        .RespValid(RespValid), .RespReady(RespReady),
        .RespResult(RespResult), .RespZero(RespZero),
        .ALUControl(ALUControl), .ALUA(ALUA), .ALUB(ALUB),
        .ALUResult(ALUResult), .ALUZero(ALUZero)
    );

    // Behavioural ALU: branch ops return 1/Zero=1 when taken, unknown codes return 0/Zero=1.
    function automatic logic [32:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        br, isbr;
        r = 32'd0; br = 1'b0; isbr = 1'b0;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_MUL:  r = a * b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_BGEZ: begin isbr = 1'b1; br = ($signed(a) >= 0); end
            ALU_BEQ:  begin isbr = 1'b1; br = (a == b); end
            ALU_BNE:  begin isbr = 1'b1; br = (a != b); end
            ALU_BGTZ: begin isbr = 1'b1; br = ($signed(a) > 0); end
            ALU_BLEZ: begin isbr = 1'b1; br = ($signed(a) <= 0); end
            ALU_BLTZ: begin isbr = 1'b1; br = ($signed(a) < 0); end
            default:  r = 32'd0;
        endcase
        if (isbr) return {br, 31'd0, br};
        return {(r == 32'd0), r};
    endfunction

    assign {ALUZero, ALUResult} = alu_f(ALUControl, ALUA, ALUB);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting at cycle %0d", name, cyc);
    endtask

    // Transaction model: one operation in flight, response due a fixed number of cycles after accept.
    int          cyc = 0;
    bit          m_busy = 1'b0, m_owner = 1'b0, m_ptr = 1'b0;
    int          m_resp = 0;
    logic [4:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic        m_zero = 1'b0;
    logic [1:0]  m_g;

    function automatic logic [1:0] pick(input logic [1:0] v, input bit p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
        end else begin
            if (!m_busy) begin
                m_g = pick(ReqValid, m_ptr);
                if (m_g != 2'b00) begin
                    m_busy  = 1'b1;
                    m_owner = m_g[1];
                    m_op    = m_g[1] ? ReqOp1 : ReqOp0;
                    m_a     = m_g[1] ? ReqA1  : ReqA0;
                    m_b     = m_g[1] ? ReqB1  : ReqB0;
                    {m_zero, m_res} = alu_f(m_op, m_a, m_b);
                    m_resp  = cyc + 2 + ((m_op == ALU_MUL) ? MUL_LAT : 0);
                end
            end else if ((cyc >= m_resp) && RespReady[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = ~m_owner;
            end
            cyc++;
        end
    end

    always @(negedge Clk) begin
        bit in_resp, in_alu;
        if (!Reset_n) begin
            checkOutput("rst_ReqReady", 32'(ReqReady), 32'd0);
            checkOutput("rst_RespValid", 32'(RespValid), 32'd0);
            checkOutput("rst_ALUControl", 32'(ALUControl), 32'd0);
            checkOutput("rst_ALUA", ALUA, 32'd0);
            checkOutput("rst_ALUB", ALUB, 32'd0);
            checkOutput("rst_RespResult", RespResult, 32'd0);
            checkOutput("rst_RespZero", 32'(RespZero), 32'd0);
        end else begin
            in_resp = m_busy && (cyc >= m_resp);
            in_alu  = m_busy && !in_resp;
            checkOutput("ReqReady", 32'(ReqReady), m_busy ? 32'd0 : 32'(pick(ReqValid, m_ptr)));
            checkOutput("RespValid", 32'(RespValid), in_resp ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
            checkOutput("ALUControl", 32'(ALUControl), in_alu ? 32'(m_op) : 32'd0);
            checkOutput("ALUA", ALUA, in_alu ? m_a : 32'd0);
            checkOutput("ALUB", ALUB, in_alu ? m_b : 32'd0);
            if (in_resp) begin
                checkOutput("RespResult", RespResult, m_res);
                checkOutput("RespZero", 32'(RespZero), 32'(m_zero));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic setReq(input int id, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin ReqOp0 = op; ReqA0 = a; ReqB0 = b; end
        else         begin ReqOp1 = op; ReqA1 = a; ReqB1 = b; end
    endtask

    // Raises one request and returns the cycle it was accepted in; call just after a tick.
    task automatic applyStimulus(input int id, input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output int acc);
        setReq(id, op, a, b);
        ReqValid[id] = 1'b1;
        acc = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge Clk);
            if (ReqReady[id]) begin
                acc = cyc;
                break;
            end
        end
        tick();
        ReqValid[id] = 1'b0;
        if (acc < 0) timeoutFail("accept");
    endtask

    task automatic waitResp(input int id, output int rc, output logic [31:0] res, output logic z);
        rc = -1; res = '0; z = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge Clk);
            if (RespValid[id]) begin
                rc = cyc; res = RespResult; z = RespZero;
                break;
            end
        end
        if (rc < 0) timeoutFail("response");
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          acc, rc, k, held, seen;
        logic [31:0] res;
        logic        z;
        logic [1:0]  got [4];
        logic [1:0]  hs;
        bit          pend [2];
        logic [4:0]  ops [15];

        ops = '{ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLL, ALU_SRL, ALU_AND, ALU_OR, ALU_XOR,
                ALU_NOR, ALU_SLT, ALU_BEQ, ALU_BNE, ALU_BGTZ, ALU_BLTZ, 5'b11111};

        #1 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;

        // Contention: both requesters hold valid; grants must alternate starting with 0.
        RespReady = 2'b11;
        setReq(0, ALU_SUB, 32'd10, 32'd3);
        setReq(1, ALU_SUB, 32'd20, 32'd5);
        ReqValid = 2'b11;
        k = 0;
        for (int n = 0; n < 100 && k < 4; n++) begin
            @(negedge Clk);
            if (ReqReady != 2'b00) begin
                got[k] = ReqReady;
                k++;
            end
        end
        tick();
        ReqValid = 2'b00;
        if (k < 4) timeoutFail("fairness");
        else for (int i = 0; i < 4; i++) checkOutput($sformatf("fair_grant%0d", i), 32'(got[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        repeat (4) tick();

        applyStimulus(0, ALU_ADD, 32'd7, 32'd5, acc);
        waitResp(0, rc, res, z);
        checkOutput("add_latency", 32'(rc - acc), 32'd2);
        checkOutput("add_result", res, 32'd12);
        checkOutput("add_zero", 32'(z), 32'd0);
        @(negedge Clk);
        checkOutput("add_aluctl_after", 32'(ALUControl), 32'd0);

        tick();
        applyStimulus(1, ALU_MUL, 32'd6, 32'd7, acc);
        held = 0; rc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (RespValid[1]) begin rc = cyc; res = RespResult; break; end
            if (ALUA == 32'd6 && ALUB == 32'd7) held++;
        end
        if (rc < 0) timeoutFail("mul_resp");
        checkOutput("mul_latency", 32'(rc - acc), 32'd4);
        checkOutput("mul_result", res, 32'd42);
        checkOutput("mul_hold_cycles", 32'(held), 32'd3);

        // Response backpressure with a waiting second requester.
        tick();
        RespReady = 2'b00;
        applyStimulus(0, ALU_BEQ, 32'd9, 32'd9, acc);
        setReq(1, ALU_ADD, 32'd100, 32'd23);
        ReqValid[1] = 1'b1;
        waitResp(0, rc, res, z);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge Clk);
            checkOutput("bp_RespValid", 32'(RespValid), 32'd1);
            checkOutput("bp_RespResult", RespResult, 32'd1);
            checkOutput("bp_RespZero", 32'(RespZero), 32'd1);
            checkOutput("bp_ReqReady1", 32'(ReqReady[1]), 32'd0);
        end
        tick();
        RespReady = 2'b01;
        @(negedge Clk);
        checkOutput("bp_no_same_cycle_accept", 32'(ReqReady), 32'd0);
        tick();
        RespReady = 2'b11;
        @(negedge Clk);
        checkOutput("bp_req1_accept_next", 32'(ReqReady), 32'd2);
        tick();
        ReqValid[1] = 1'b0;
        waitResp(1, rc, res, z);
        checkOutput("bp_req1_result", res, 32'd123);

        tick();
        applyStimulus(0, 5'b11111, 32'd3, 32'd4, acc);
        waitResp(0, rc, res, z);
        checkOutput("undef_latency", 32'(rc - acc), 32'd2);
        checkOutput("undef_result", res, 32'd0);
        checkOutput("undef_zero", 32'(z), 32'd1);

        // Reset asserted while a multiply is in MULWAIT.
        tick();
        applyStimulus(0, ALU_MUL, 32'd9, 32'd9, acc);
        @(negedge Clk);
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        checkOutput("async_rst_ALUA", ALUA, 32'd0);
        checkOutput("async_rst_ALUControl", 32'(ALUControl), 32'd0);
        checkOutput("async_rst_RespValid", 32'(RespValid), 32'd0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge Clk);
            if (RespValid != 2'b00) seen = 1;
        end
        checkOutput("no_resp_after_reset", 32'(seen), 32'd0);
        tick();
        applyStimulus(0, ALU_ADD, 32'd1, 32'd1, acc);
        waitResp(0, rc, res, z);
        checkOutput("post_rst_add_result", res, 32'd2);
        checkOutput("post_rst_add_latency", 32'(rc - acc), 32'd2);

        // Randomized traffic: requesters hold their request until accepted.
        tick();
        pend[0] = 1'b0; pend[1] = 1'b0;
        hs = 2'b00;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && hs[i]) pend[i] = 1'b0;
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    logic [31:0] a, b;
                    a = ($urandom % 2 == 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
                    b = ($urandom % 4 == 0) ? a : 32'($urandom_range(0, 40));
                    setReq(i, ops[$urandom_range(0, 14)], a, b);
                    pend[i] = 1'b1;
                end
                ReqValid[i] = pend[i];
            end
            RespReady = 2'($urandom);
            @(negedge Clk);
            hs = ReqValid & ReqReady;
            tick();
        end
        ReqValid  = 2'b00;
        RespReady = 2'b11;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
